// File: rtl/display_scanner.sv
// display_scanner: time-multiplexed 7-seg digit scanner with double-buffered
// digit data, per-digit enable/blink and PWM brightness.
//
// Ports:
//   clk, rst     clock; synchronous active-high reset
//   hexs         nibble per digit (digit k = hexs[4k+3:4k])
//   points, LEs  per-digit point / LE values
//   en, blink    per-digit enable and blink select
//   load         strobe: stage all data inputs into the pending buffer
//   brightness   PWM duty; values >= 2^BRIGHT_W mean full on
//   HEX, point, LE  registered data of the current digit
//   AN           registered active-low anodes (one low or all high)
//   scan         current digit index
//   frame_done   one-cycle pulse after each frame wrap
module display_scanner #(
   parameter int DIGITS       = 8,
   parameter int PRESCALE     = 50000,
   parameter int BRIGHT_W     = 4,
   parameter int BLINK_FRAMES = 64,
   localparam int SW          = $clog2(DIGITS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*DIGITS-1:0]   hexs,
   input  logic [DIGITS-1:0]     points,
   input  logic [DIGITS-1:0]     LEs,
   input  logic [DIGITS-1:0]     en,
   input  logic [DIGITS-1:0]     blink,
   input  logic                  load,
   input  logic [BRIGHT_W:0]     brightness,
   output logic [3:0]            HEX,
   output logic [DIGITS-1:0]     AN,
   output logic                  point,
   output logic                  LE,
   output logic [SW-1:0]         scan,
   output logic                  frame_done
);

   localparam int PW = $clog2(PRESCALE);
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [PW-1:0]           presc_q, presc_d;
   logic [SW-1:0]           scan_q, scan_d;
   logic [BRIGHT_W-1:0]     pwm_q, pwm_d;
   logic [FW-1:0]           fcnt_q, fcnt_d;
   logic                    phase_q, phase_d;
   logic                    pflag_q, pflag_d;
   logic                    fd_q, fd_d;

   logic [DIGITS-1:0][3:0]  act_hex_q, act_hex_d;
   logic [DIGITS-1:0]       act_pt_q, act_pt_d;
   logic [DIGITS-1:0]       act_le_q, act_le_d;
   logic [DIGITS-1:0]       act_en_q, act_en_d;
   logic [DIGITS-1:0]       act_bl_q, act_bl_d;

   logic [DIGITS-1:0][3:0]  pend_hex_q, pend_hex_d;
   logic [DIGITS-1:0]       pend_pt_q, pend_pt_d;
   logic [DIGITS-1:0]       pend_le_q, pend_le_d;
   logic [DIGITS-1:0]       pend_en_q, pend_en_d;
   logic [DIGITS-1:0]       pend_bl_q, pend_bl_d;

   logic [3:0]              hex_q, hex_d;
   logic [DIGITS-1:0]       an_q, an_d;
   logic                    pt_q, pt_d;
   logic                    le_q, le_d;

   logic tick, wrap, lit;

   always_comb begin
      presc_d    = presc_q;
      scan_d     = scan_q;
      pwm_d      = pwm_q + BRIGHT_W'(1);
      fcnt_d     = fcnt_q;
      phase_d    = phase_q;
      pflag_d    = pflag_q;
      act_hex_d  = act_hex_q;
      act_pt_d   = act_pt_q;
      act_le_d   = act_le_q;
      act_en_d   = act_en_q;
      act_bl_d   = act_bl_q;
      pend_hex_d = pend_hex_q;
      pend_pt_d  = pend_pt_q;
      pend_le_d  = pend_le_q;
      pend_en_d  = pend_en_q;
      pend_bl_d  = pend_bl_q;

      tick = (presc_q == PW'(PRESCALE - 1));
      wrap = tick && (scan_q == SW'(DIGITS - 1));
      fd_d = wrap;

      presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick)
         scan_d = wrap ? '0 : scan_q + SW'(1);

      if (wrap) begin
         if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
            fcnt_d  = '0;
            phase_d = ~phase_q;
         end else begin
            fcnt_d = fcnt_q + FW'(1);
         end
      end

      // Frame boundary promotes the pre-edge pending copy; a load in the
      // same cycle refills pending and keeps the flag set.
      if (wrap && pflag_q) begin
         act_hex_d = pend_hex_q;
         act_pt_d  = pend_pt_q;
         act_le_d  = pend_le_q;
         act_en_d  = pend_en_q;
         act_bl_d  = pend_bl_q;
      end

      if (load) begin
         pend_hex_d = hexs;
         pend_pt_d  = points;
         pend_le_d  = LEs;
         pend_en_d  = en;
         pend_bl_d  = blink;
         pflag_d    = 1'b1;
      end else if (wrap) begin
         pflag_d = 1'b0;
      end

      lit = act_en_q[scan_q]
            & ~(act_bl_q[scan_q] & phase_q)
            & ({1'b0, pwm_q} < brightness);

      hex_d = act_hex_q[scan_q];
      pt_d  = act_pt_q[scan_q];
      le_d  = act_le_q[scan_q];
      an_d  = '1;
      if (lit)
         an_d[scan_q] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q    <= '0;
         scan_q     <= '0;
         pwm_q      <= '0;
         fcnt_q     <= '0;
         phase_q    <= 1'b0;
         pflag_q    <= 1'b0;
         fd_q       <= 1'b0;
         act_hex_q  <= '0;
         act_pt_q   <= '0;
         act_le_q   <= '0;
         act_en_q   <= '0;
         act_bl_q   <= '0;
         pend_hex_q <= '0;
         pend_pt_q  <= '0;
         pend_le_q  <= '0;
         pend_en_q  <= '0;
         pend_bl_q  <= '0;
         hex_q      <= '0;
         an_q       <= '1;
         pt_q       <= 1'b0;
         le_q       <= 1'b0;
      end else begin
         presc_q    <= presc_d;
         scan_q     <= scan_d;
         pwm_q      <= pwm_d;
         fcnt_q     <= fcnt_d;
         phase_q    <= phase_d;
         pflag_q    <= pflag_d;
         fd_q       <= fd_d;
         act_hex_q  <= act_hex_d;
         act_pt_q   <= act_pt_d;
         act_le_q   <= act_le_d;
         act_en_q   <= act_en_d;
         act_bl_q   <= act_bl_d;
         pend_hex_q <= pend_hex_d;
         pend_pt_q  <= pend_pt_d;
         pend_le_q  <= pend_le_d;
         pend_en_q  <= pend_en_d;
         pend_bl_q  <= pend_bl_d;
         hex_q      <= hex_d;
         an_q       <= an_d;
         pt_q       <= pt_d;
         le_q       <= le_d;
      end
   end

   assign HEX        = hex_q;
   assign AN         = an_q;
   assign point      = pt_q;
   assign LE         = le_q;
   assign scan       = scan_q;
   assign frame_done = fd_q;

endmodule

// File: tb/tb_display_scanner.sv
// Bench for display_scanner (DIGITS=4, PRESCALE=4, BRIGHT_W=4,
// BLINK_FRAMES=2): directed table plus randomized cycle-count model.
module tb_display_scanner;

   localparam int D  = 4;
   localparam int P  = 4;
   localparam int BW = 4;
   localparam int BF = 2;
   localparam int FR = P * D;

   logic          clk = 1'b0;
   logic          rst;
   logic [4*D-1:0] hexs;
   logic [D-1:0]  points, LEs, en, blink;
   logic          load;
   logic [BW:0]   brightness;
   logic [3:0]    HEX;
   logic [D-1:0]  AN;
   logic          point, LE;
   logic [1:0]    scan;
   logic          frame_done;

   always #5 clk = ~clk;

   display_scanner #(
      .DIGITS(D), .PRESCALE(P), .BRIGHT_W(BW), .BLINK_FRAMES(BF)
   ) dut (
      .clk(clk), .rst(rst), .hexs(hexs), .points(points), .LEs(LEs),
      .en(en), .blink(blink), .load(load), .brightness(brightness),
      .HEX(HEX), .AN(AN), .point(point), .LE(LE), .scan(scan),
      .frame_done(frame_done)
   );

   int nvec = 0;
   int nerr = 0;

   // Model: everything timing-related follows from the number of clocks c
   // since the last reset; the two buffers are tracked as plain records.
   int c = 0;
   logic [15:0] a_hex, p_hex;
   logic [3:0]  a_pt, a_le, a_en, a_bl, p_pt, p_le, p_en, p_bl;
   logic        p_flag;

   task automatic model_clear();
      c = 0;
      a_hex = '0; a_pt = '0; a_le = '0; a_en = '0; a_bl = '0;
      p_hex = '0; p_pt = '0; p_le = '0; p_en = '0; p_bl = '0;
      p_flag = 1'b0;
   endtask

   task automatic step();
      int s, pw, ph, sn;
      logic wr, lit;
      logic [3:0] e_hex, e_an;
      logic e_pt, e_le, e_fd;
      logic [1:0] e_sc;
      s  = (c / P) % D;
      pw = c % (1 << BW);
      ph = ((c / FR) / BF) % 2;
      wr = (c % FR) == FR - 1;
      sn = ((c + 1) / P) % D;
      if (rst) begin
         e_hex = 0; e_an = 4'hF; e_pt = 0; e_le = 0; e_sc = 0; e_fd = 0;
      end else begin
         lit = a_en[s] && !(a_bl[s] && ph == 1) && (pw < int'(brightness));
         e_hex = a_hex[4*s +: 4];
         e_an  = lit ? ~(4'b0001 << s) : 4'hF;
         e_pt  = a_pt[s];
         e_le  = a_le[s];
         e_sc  = 2'(sn);
         e_fd  = wr;
      end
      @(posedge clk);
      #1;
      nvec++;
      if ({HEX, AN, point, LE, scan, frame_done} !==
          {e_hex, e_an, e_pt, e_le, e_sc, e_fd}) begin
         nerr++;
         $display("FAIL model c=%0d: got HEX=%h AN=%b pt=%b LE=%b scan=%0d fd=%b, want HEX=%h AN=%b pt=%b LE=%b scan=%0d fd=%b",
                  c, HEX, AN, point, LE, scan, frame_done,
                  e_hex, e_an, e_pt, e_le, e_sc, e_fd);
      end
      if (rst) begin
         model_clear();
      end else begin
         if (wr && p_flag) begin
            a_hex = p_hex; a_pt = p_pt; a_le = p_le;
            a_en = p_en; a_bl = p_bl;
         end
         if (load) begin
            p_hex = hexs; p_pt = points; p_le = LEs;
            p_en = en; p_bl = blink; p_flag = 1'b1;
         end else if (wr) begin
            p_flag = 1'b0;
         end
         c++;
      end
   endtask

   typedef struct {
      logic        rs;
      logic        ld;
      logic [15:0] hx;
      logic [4:0]  br;
      int          n;
      logic [3:0]  an;
      logic [3:0]  hex;
      logic [1:0]  sc;
      logic        fd;
   } vec_t;

   vec_t tbl[20];

   initial begin
      tbl[0]  = '{1, 0, 16'h0000, 16,  1, 4'hF, 4'h0, 0, 0};
      tbl[1]  = '{0, 1, 16'h4321, 16,  1, 4'hF, 4'h0, 0, 0};
      tbl[2]  = '{0, 0, 16'h4321, 16, 15, 4'hF, 4'h0, 0, 1};
      tbl[3]  = '{0, 0, 16'h4321, 16,  1, 4'hE, 4'h1, 0, 0};
      tbl[4]  = '{0, 0, 16'h4321, 16,  4, 4'hD, 4'h2, 1, 0};
      tbl[5]  = '{0, 1, 16'hABCD, 16,  1, 4'hD, 4'h2, 1, 0};
      tbl[6]  = '{0, 0, 16'hABCD, 16, 10, 4'h7, 4'h4, 0, 1};
      tbl[7]  = '{0, 0, 16'hABCD, 16,  1, 4'hE, 4'hD, 0, 0};
      tbl[8]  = '{0, 1, 16'h1111, 16,  1, 4'hE, 4'hD, 0, 0};
      tbl[9]  = '{0, 0, 16'h1111, 16, 13, 4'h7, 4'hA, 3, 0};
      tbl[10] = '{0, 1, 16'h2222, 16,  1, 4'h7, 4'hA, 0, 1};
      tbl[11] = '{0, 0, 16'h2222, 16, 16, 4'h7, 4'h1, 0, 1};
      tbl[12] = '{0, 0, 16'h2222, 16,  1, 4'hE, 4'h2, 0, 0};
      tbl[13] = '{0, 0, 16'h2222,  4,  3, 4'hE, 4'h2, 1, 0};
      tbl[14] = '{0, 0, 16'h2222,  4,  1, 4'hF, 4'h2, 1, 0};
      tbl[15] = '{0, 0, 16'h2222,  0, 12, 4'hF, 4'h2, 0, 0};
      tbl[16] = '{0, 0, 16'h2222, 16,  8, 4'hB, 4'h2, 2, 0};
      tbl[17] = '{0, 0, 16'h2222, 16,  1, 4'hB, 4'h2, 2, 0};
      tbl[18] = '{1, 0, 16'h2222, 16,  1, 4'hF, 4'h0, 0, 0};
      tbl[19] = '{0, 0, 16'h2222, 16, 20, 4'hF, 4'h0, 1, 0};

      model_clear();
      rst = 1; load = 0; hexs = '0; points = '0; LEs = '0;
      en = 4'hF; blink = '0; brightness = 5'd16;
      #1;

      for (int i = 0; i < 20; i++) begin
         rst = tbl[i].rs;
         load = tbl[i].ld;
         hexs = tbl[i].hx;
         brightness = tbl[i].br;
         for (int k = 0; k < tbl[i].n; k++) begin
            step();
            load = 1'b0;
         end
         nvec++;
         if ({AN, HEX, scan, frame_done} !==
             {tbl[i].an, tbl[i].hex, tbl[i].sc, tbl[i].fd}) begin
            nerr++;
            $display("FAIL table[%0d]: got AN=%b HEX=%h scan=%0d fd=%b, want AN=%b HEX=%h scan=%0d fd=%b",
                     i, AN, HEX, scan, frame_done,
                     tbl[i].an, tbl[i].hex, tbl[i].sc, tbl[i].fd);
         end
      end

      // Blink: digit 0 dark for frames 2-3 of every 4, others lit.
      rst = 1; load = 0; step();
      rst = 0; load = 1; hexs = 16'h9876; en = 4'hF;
      blink = 4'b0001; brightness = 5'd31;
      step();
      load = 0;
      for (int k = 0; k < 6 * FR; k++) step();

      // Randomized traffic.
      for (int k = 0; k < 4000; k++) begin
         rst        = ($urandom_range(0, 299) == 0);
         load       = ($urandom_range(0, 5) == 0);
         hexs       = 16'($urandom);
         points     = 4'($urandom);
         LEs        = 4'($urandom);
         en         = 4'($urandom);
         blink      = 4'($urandom);
         if ($urandom_range(0, 63) == 0)
            brightness = 5'($urandom);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/display_scanner.md
DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 Parameter DIGITS, default 8: number of multiplexed digits; legal 2..16.
REQ-002 Parameter PRESCALE, default 50000: clocks per digit slot; legal >= 2.
REQ-003 Parameter BRIGHT_W, default 4: PWM counter width.
REQ-004 Parameter BLINK_FRAMES, default 64: frames per blink half-period; legal >= 1.
REQ-005 Local SW = $clog2(DIGITS).
REQ-006 clk  in  1  sole clock; all state updates on rising edge.
REQ-007 rst  in  1  reset; synchronous, active-high.
REQ-008 hexs  in  4*DIGITS  nibble per digit; digit k = hexs[4k+3:4k].
REQ-009 points  in  DIGITS  decimal point per digit.
REQ-010 LEs  in  DIGITS  per-digit LE value, passed through.
REQ-011 en  in  DIGITS  per-digit enable; 0 = digit dark.
REQ-012 blink  in  DIGITS  per-digit blink select.
REQ-013 load  in  1  strobe; stage all data inputs.
REQ-014 brightness  in  BRIGHT_W+1  PWM duty; values >= 2^BRIGHT_W = full on.
REQ-015 HEX  out  4  nibble of current digit.
REQ-016 AN  out  DIGITS  digit anodes, active-low, one-hot-low or all ones.
REQ-017 point  out  1  point of current digit.
REQ-018 LE  out  1  LE of current digit.
REQ-019 scan  out  SW  current digit index.
REQ-020 frame_done  out  1  one-cycle pulse at frame wrap.

Function
REQ-021 Prescaler counts 0..PRESCALE-1 every clock; tick asserted when count = PRESCALE-1; count then wraps to 0.
REQ-022 On tick, scan increments; at scan = DIGITS-1 it wraps to 0 (wrap tick); non-power-of-2 DIGITS never reaches index >= DIGITS.
REQ-023 frame_done high exactly the cycle after each wrap tick, for one cycle.
REQ-024 Double buffer: load=1 copies hexs/points/LEs/en/blink into pending registers and sets pending flag that cycle.
REQ-025 On wrap tick with pending flag set, active registers take pending registers' pre-edge value and flag clears.
REQ-026 load coincident with wrap tick: active takes pre-edge pending contents, pending takes new inputs, flag remains set.
REQ-027 Display outputs use active registers only; mid-frame load never alters the displayed frame.
REQ-028 Frame counter counts wrap ticks 0..BLINK_FRAMES-1; on reaching BLINK_FRAMES-1 and wrap tick, wraps to 0 and toggles blink phase.
REQ-029 PWM counter (BRIGHT_W bits) free-runs +1 per clock, wrapping.
REQ-030 Digit k lit iff scan = k, en[k]=1, not (blink[k]=1 and phase=1), and {0,pwm} < brightness.
REQ-031 AN[k]=0 only when digit k lit; otherwise AN bit = 1; brightness = 0 keeps AN all ones.
REQ-032 HEX/point/LE reflect active nibble/point/LE of digit scan regardless of lit state.
REQ-033 HEX, AN, point, LE are registered: value at edge n derives from scan, active regs, phase, pwm before edge n (1-cycle latency).

Reset
REQ-034 rst=1 at edge: prescaler, scan, PWM, frame counter, phase, pending flag = 0.
REQ-035 Reset clears active and pending registers to 0, so all digits dark until first load then wrap.
REQ-036 Reset outputs: HEX=0, AN=all ones, point=0, LE=0, scan=0, frame_done=0.
REQ-037 rst dominates load and tick in same cycle; mid-frame reset restarts from scan 0 with prescaler 0.

Verification
REQ-038 DIGITS=4, PRESCALE=4, brightness=16, load hexs=16'h4321, en=4'hF at reset release -> after first wrap, AN cycles 1110,1101,1011,0111 each 4 clocks, HEX 1,2,3,4, frame_done every 16 clocks.
REQ-039 Mid-frame load hexs=16'hABCD -> current frame still shows 1..4; next frame shows D,C,B,A.
REQ-040 load asserted on wrap-tick cycle -> previous pending contents displayed; new data displayed one frame later.
REQ-041 brightness=4, BRIGHT_W=4 -> selected AN low exactly 4 of every 16 clocks; brightness=0 -> AN all ones.
REQ-042 BLINK_FRAMES=2, blink=4'b0001 -> digit 0 dark for frames 2-3, lit frames 0-1 and 4-5; other digits always lit.
REQ-043 rst pulse mid-slot with scan=2 -> next cycle scan=0, AN=all ones, active cleared; display dark until load and wrap.
